// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared register-file types and writeback scheduler states
package cpu_types_pkg;

   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      WAIT  = ST_WAIT,
      FORCE = ST_FORCE
   } sched_state_t;

   function automatic word_t reg_mask(input regbits_t sel);
      return word_t'(1) << sel;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits for outstanding long-latency destinations
module rf_scoreboard
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        set_en,
   input  logic [4:0]  set_sel,
   input  logic        clr_en,
   input  logic [4:0]  clr_sel,
   input  logic [4:0]  rd1_sel,
   input  logic [4:0]  rd2_sel,
   input  logic [4:0]  iss_sel,
   output logic        rd1_busy,
   output logic        rd2_busy,
   output logic        iss_busy,
   output logic [31:0] busy
);

   word_t set_m, clr_m, busy_n;

   // set is applied after clear so a same-cycle reissue keeps the register busy
   always_comb begin
      set_m  = set_en ? reg_mask(set_sel) : '0;
      clr_m  = clr_en ? reg_mask(clr_sel) : '0;
      busy_n = ((busy & ~clr_m) | set_m) & 32'hFFFF_FFFE;
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) busy <= '0;
      else       busy <= busy_n;
   end

   assign rd1_busy = busy[rd1_sel];
   assign rd2_busy = busy[rd2_sel];
   assign iss_busy = busy[iss_sel];

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file write port arbiter with RAW/WAW scoreboard and starvation guard
module rf_wb_scheduler
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        pwb_wen,
   input  logic [4:0]  pwb_wsel,
   input  logic [31:0] pwb_wdat,
   input  logic        lu_valid,
   input  logic [4:0]  lu_wsel,
   input  logic [31:0] lu_wdat,
   output logic        lu_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_wsel,
   output logic        iss_ready,
   input  logic [4:0]  chk_rsel1,
   input  logic [4:0]  chk_rsel2,
   output logic        stall,
   output logic        pipe_hold,
   output logic        rf_WEN,
   output logic [4:0]  rf_wsel,
   output logic [31:0] rf_wdat,
   output logic [31:0] busy_vec
);

   sched_state_t     state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             hold_q;
   logic             pwb_eff, lu_xfer, iss_fire;
   logic             rd1_busy, rd2_busy, iss_busy;

   assign pwb_eff = pwb_wen && (pwb_wsel != 5'd0);

   always_comb begin
      lu_ready = 1'b1;
      rf_WEN   = lu_valid;
      rf_wsel  = lu_wsel;
      rf_wdat  = lu_wdat;
      if (state_q != FORCE && pwb_eff) begin
         lu_ready = 1'b0;
         rf_WEN   = pwb_wen;
         rf_wsel  = pwb_wsel;
         rf_wdat  = pwb_wdat;
      end
   end

   assign lu_xfer   = lu_valid && lu_ready;
   assign iss_ready = !iss_busy;
   assign iss_fire  = iss_valid && iss_ready && (iss_wsel != 5'd0);
   assign stall     = rd1_busy | rd2_busy;

   rf_scoreboard u_sb (
      .CLK      (CLK),
      .nRST     (nRST),
      .set_en   (iss_fire),
      .set_sel  (iss_wsel),
      .clr_en   (lu_xfer),
      .clr_sel  (lu_wsel),
      .rd1_sel  (chk_rsel1),
      .rd2_sel  (chk_rsel2),
      .iss_sel  (iss_wsel),
      .rd1_busy (rd1_busy),
      .rd2_busy (rd2_busy),
      .iss_busy (iss_busy),
      .busy     (busy_vec)
   );

   // counter counts blocked cycles; reaching STARVE_MAX enters FORCE on the same edge
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      case (state_q)
         IDLE: begin
            if (lu_valid && !lu_ready) begin
               state_n = WAIT;
               cnt_n   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (!lu_valid || lu_ready) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt_q >= CNT_W'(STARVE_MAX - 1)) begin
               state_n = FORCE;
               cnt_n   = CNT_W'(STARVE_MAX);
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         FORCE: begin
            if (lu_xfer) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         hold_q  <= (state_n == FORCE);
      end
   end

   assign pipe_hold = hold_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed scoreboard bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

   logic        CLK, nRST;
   logic        pwb_wen, lu_valid, lu_ready, iss_valid, iss_ready;
   logic [4:0]  pwb_wsel, lu_wsel, iss_wsel, chk_rsel1, chk_rsel2, rf_wsel;
   logic [31:0] pwb_wdat, lu_wdat, rf_wdat, busy_vec;
   logic        stall, pipe_hold, rf_WEN;

   typedef struct packed {
      logic [4:0]  wsel;
      logic [31:0] wdat;
   } wr_t;

   wr_t exp_q[$];
   int  ncmp  = 0;
   int  nfail = 0;

   rf_wb_scheduler dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .pwb_wen   (pwb_wen),
      .pwb_wsel  (pwb_wsel),
      .pwb_wdat  (pwb_wdat),
      .lu_valid  (lu_valid),
      .lu_wsel   (lu_wsel),
      .lu_wdat   (lu_wdat),
      .lu_ready  (lu_ready),
      .iss_valid (iss_valid),
      .iss_wsel  (iss_wsel),
      .iss_ready (iss_ready),
      .chk_rsel1 (chk_rsel1),
      .chk_rsel2 (chk_rsel2),
      .stall     (stall),
      .pipe_hold (pipe_hold),
      .rf_WEN    (rf_WEN),
      .rf_wsel   (rf_wsel),
      .rf_wdat   (rf_wdat),
      .busy_vec  (busy_vec)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] s, input logic [31:0] d);
      wr_t e;
      e.wsel = s;
      e.wdat = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      pwb_wen = 0; pwb_wsel = 0; pwb_wdat = 0;
      lu_valid = 0; lu_wsel = 0; lu_wdat = 0;
      iss_valid = 0; iss_wsel = 0;
   endtask

   // every committed write must match the oldest expected write
   always @(negedge CLK) begin
      if (nRST === 1'b1 && rf_WEN === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("pending_writes", exp_q.size(), 1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_wsel", rf_wsel, e.wsel);
            chk("wr_wdat", rf_wdat, e.wdat);
         end
      end
   end

   initial begin
      idle_inputs();
      chk_rsel1 = 0; chk_rsel2 = 0;
      nRST = 0;
      pwb_wen = 1; pwb_wsel = 5; pwb_wdat = 32'h0000_0055;
      @(negedge CLK);
      chk("rst_busy_vec", busy_vec, 0);
      chk("rst_pipe_hold", pipe_hold, 0);
      chk("rst_rf_WEN", rf_WEN, 1);
      chk("rst_rf_wsel", rf_wsel, 5);
      chk("rst_lu_ready", lu_ready, 0);
      tick();
      nRST = 1;
      expect_wr(5, 32'h0000_0055);
      @(negedge CLK);
      chk("post_rst_hold", pipe_hold, 0);

      // RAW stall on an issued long-latency destination
      tick();
      idle_inputs();
      iss_valid = 1; iss_wsel = 8; chk_rsel1 = 8;
      @(negedge CLK);
      chk("iss8_ready", iss_ready, 1);
      chk("iss8_stall_before", stall, 0);
      tick();
      iss_valid = 0;
      @(negedge CLK);
      chk("iss8_busy_vec", busy_vec, 32'h0000_0100);
      chk("iss8_stall", stall, 1);
      chk("iss8_waw", iss_ready, 0);
      tick();
      lu_valid = 1; lu_wsel = 8; lu_wdat = 32'hDEAD_BEEF;
      expect_wr(8, 32'hDEAD_BEEF);
      @(negedge CLK);
      chk("lu8_ready", lu_ready, 1);
      chk("lu8_stall_same_cycle", stall, 1);
      tick();
      lu_valid = 0;
      @(negedge CLK);
      chk("lu8_busy_clear", busy_vec, 0);
      chk("lu8_stall_clear", stall, 0);

      // starvation: pipeline writes every cycle while lu waits
      tick();
      iss_valid = 1; iss_wsel = 20;
      tick();
      iss_valid = 0;
      lu_valid = 1; lu_wsel = 20; lu_wdat = 32'hA5A5_0014;
      pwb_wen = 1;
      for (int c = 1; c <= 4; c++) begin
         pwb_wsel = 5'(c);
         pwb_wdat = 32'h0000_1000 + 32'(c);
         expect_wr(5'(c), 32'h0000_1000 + 32'(c));
         @(negedge CLK);
         chk("starve_lu_ready", lu_ready, 0);
         chk("starve_hold", pipe_hold, 0);
         tick();
      end
      pwb_wsel = 7; pwb_wdat = 32'h77;
      expect_wr(20, 32'hA5A5_0014);
      @(negedge CLK);
      chk("force_hold", pipe_hold, 1);
      chk("force_lu_ready", lu_ready, 1);
      chk("force_busy_vec", busy_vec, 32'h0010_0000);
      tick();
      idle_inputs();
      @(negedge CLK);
      chk("force_exit_hold", pipe_hold, 0);
      chk("force_exit_busy", busy_vec, 0);

      // pipeline write to r0 does not occupy the port
      tick();
      pwb_wen = 1; pwb_wsel = 0; pwb_wdat = 32'h1234;
      lu_valid = 1; lu_wsel = 6; lu_wdat = 32'h66;
      expect_wr(6, 32'h66);
      @(negedge CLK);
      chk("r0_lu_ready", lu_ready, 1);
      tick();
      idle_inputs();

      // WAW block, then same-cycle clear and set of r12
      iss_valid = 1; iss_wsel = 12;
      @(negedge CLK);
      chk("iss12_ready", iss_ready, 1);
      tick();
      iss_valid = 0;
      @(negedge CLK);
      chk("iss12_waw", iss_ready, 0);
      chk("iss12_busy_vec", busy_vec, 32'h0000_1000);
      tick();
      lu_valid = 1; lu_wsel = 12; lu_wdat = 32'hC;
      expect_wr(12, 32'hC);
      @(negedge CLK);
      chk("lu12_ready", lu_ready, 1);
      tick();
      lu_wdat = 32'hD; iss_valid = 1;
      expect_wr(12, 32'hD);
      @(negedge CLK);
      chk("reiss12_ready", iss_ready, 1);
      tick();
      idle_inputs();
      @(negedge CLK);
      chk("set_wins_busy_vec", busy_vec, 32'h0000_1000);

      // async reset while in FORCE with r3 outstanding
      tick();
      iss_valid = 1; iss_wsel = 3;
      tick();
      iss_valid = 0;
      lu_valid = 1; lu_wsel = 3; lu_wdat = 32'h33;
      pwb_wen = 1;
      for (int c = 1; c <= 4; c++) begin
         pwb_wsel = 5'(10 + c);
         pwb_wdat = 32'h0000_2000 + 32'(c);
         expect_wr(5'(10 + c), 32'h0000_2000 + 32'(c));
         tick();
      end
      pwb_wsel = 15; pwb_wdat = 32'hF;
      expect_wr(3, 32'h33);
      @(negedge CLK);
      chk("rst_force_hold", pipe_hold, 1);
      chk("rst_force_busy", busy_vec, 32'h0000_1008);
      #1;
      nRST = 0;
      #1;
      chk("rst_async_hold", pipe_hold, 0);
      chk("rst_async_busy", busy_vec, 0);
      chk("rst_async_lu_ready", lu_ready, 0);
      idle_inputs();
      tick();
      tick();
      nRST = 1;
      @(negedge CLK);
      chk("post_rst2_hold", pipe_hold, 0);
      chk("post_rst2_busy", busy_vec, 0);
      chk("post_rst2_lu_ready", lu_ready, 1);
      tick();
      chk("writes_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Controller for the 32x32 register file's single write port (WEN/wsel/wdat).
- Arbitrates between the in-order pipeline writeback and a long-latency unit (mult/div).
- Keeps a per-register busy scoreboard for long-latency destinations and raises RAW/WAW stalls.
- Prevents starvation of the long-latency unit by holding the pipeline when needed. Sits between the writeback stage, the mult/div unit and register_file.

Parameters:
- STARVE_MAX, 4, cycles a valid long-latency write may be blocked before the pipeline is forced to hold.
- CNT_W, 3, width of the starvation counter; must hold STARVE_MAX.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- pwb_wen  in  1  pipeline writeback request
- pwb_wsel  in  5  pipeline destination register
- pwb_wdat  in  32  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_wsel  in  5  long-latency destination register
- lu_wdat  in  32  long-latency write data
- lu_ready  out  1  long-latency write accepted this cycle
- iss_valid  in  1  long-latency op issuing; marks its destination busy
- iss_wsel  in  5  destination of the issuing op
- iss_ready  out  1  issue allowed (destination not busy)
- chk_rsel1  in  5  decode-stage source register 1
- chk_rsel2  in  5  decode-stage source register 2
- stall  out  1  a source register is busy (RAW)
- pipe_hold  out  1  pipeline must freeze writeback and re-present it next cycle
- rf_WEN  out  1  to register_file WEN
- rf_wsel  out  5  to register_file wsel
- rf_wdat  out  32  to register_file wdat
- busy_vec  out  32  scoreboard state (debug)

Behaviour:
- Reset (async, nRST=0):
  - busy_vec=0, FSM=IDLE, counter=0, pipe_hold=0.
  - Combinational outputs follow their inputs with the empty scoreboard: rf_WEN=pwb_wen, lu_ready=!pwb_eff.
  - Reset mid-operation discards all pending state; outstanding long ops are forgotten.
- pwb_eff = pwb_wen && pwb_wsel!=0. A pipeline write to r0 never occupies the port.
- Grant (combinational, 0-cycle latency; register file commits at the next posedge):
  - FSM=FORCE: long-latency unit granted. lu_ready=1; rf_* = lu_* when lu_valid, else rf_WEN=0. pipe_hold=1; pwb_* ignored.
  - Otherwise, pwb_eff=1: pipeline granted. rf_* = pwb_*, lu_ready=0.
  - Otherwise: lu_ready=1, rf_WEN=lu_valid, rf_wsel/rf_wdat = lu_*.
- Transfer = lu_valid && lu_ready. lu_* must stay stable while lu_valid && !lu_ready.
- Scoreboard:
  - Issue fire = iss_valid && iss_ready && iss_wsel!=0; sets busy[iss_wsel] at the posedge.
  - Transfer clears busy[lu_wsel].
  - Same-register set and clear in one cycle: set wins.
  - busy[0] is never set.
- iss_ready = !busy[iss_wsel] (WAW stall). iss_wsel=0 is always ready.
- stall = busy[chk_rsel1] | busy[chk_rsel2]. No bypass: stall deasserts the cycle after the write commits.
- FSM (registered):
  - IDLE -> WAIT when lu_valid && !lu_ready; counter set to 1.
  - WAIT: counter +1 each blocked cycle. Transfer -> IDLE with counter=0. counter==STARVE_MAX while still blocked -> FORCE.
  - FORCE -> IDLE on transfer; counter=0.
  - lu_valid dropping in WAIT -> IDLE (protocol violation tolerated).
- pipe_hold = (state==FORCE), driven from the state register only, glitch-free.
- Counter saturates at STARVE_MAX and never wraps.

Decomposition:
- cpu_types_pkg gets: regbits_t (5-bit), word_t (shared), sched_state_t enum {IDLE, WAIT, FORCE}.
- One sub-module is natural: rf_scoreboard (32-bit busy vector; set/clear ports; two read lookups plus issue lookup).
- rf_scoreboard sits alongside the arbitration FSM in rf_wb_scheduler.

Test Plan:
- Reset with pwb_wen=1, wsel=5 -> busy_vec=0, FSM=IDLE, pipe_hold=0; rf_WEN=1 passes through; after release reg5 is written at the next edge.
- Issue iss_wsel=8; chk_rsel1=8 -> stall=1 from the next cycle. lu_valid wsel=8 wdat=0xDEADBEEF with pwb idle -> lu_ready=1, reg8=0xDEADBEEF, busy[8]=0, stall=0 the cycle after.
- pwb_eff every cycle with lu_valid held -> lu_ready=0 for 4 cycles, then pipe_hold=1 and lu_ready=1 (cycle 5). Transfer -> pipe_hold=0 next cycle.
- pwb_wen=1 wsel=0 and lu_valid=1 in the same cycle -> lu granted; reg0 stays 0.
- busy[12] set, iss_wsel=12 -> iss_ready=0. Same-cycle transfer clearing 12 and issue of 12 -> busy[12] remains 1 (set wins).
- nRST pulsed while in FORCE with busy[3]=1 -> immediately pipe_hold=0, busy_vec=0, FSM=IDLE.
